instr_load_encoder: RTL

Sequential instruction encoder and loader for the single-cycle MIPS32 core. It accepts field-level instruction descriptions (opcode, register numbers, immediate) over a valid/ready stream. It packs each one into the 32-bit instruction format that the control path decodes, and writes the words into instruction memory at consecutive addresses. A load session starts on `start` and ends on the first HLT, on address exhaustion, or on reset. It is the encode side of the core's instruction decode and is used for bring-up and testbench program loading.

---
 rtl/instr_load_encoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/instr_load_encoder.sv
// instr_load_encoder
//   Packs field-level MIPS32 instruction descriptions into 32-bit words and
//   writes them into instruction memory at consecutive addresses. A session
//   begins on start (from IDLE or DONE). It ends on the first HLT, when the
//   last address is written, or on reset.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             begin a session; ignored while loading
//   in_valid/in_ready field-beat handshake; in_ready = (state == LOAD)
//   in_opcode/in_rs/in_rt/in_rd/in_imm  instruction fields
//   imem_we/imem_addr/imem_wdata        registered write port, one cycle per word
//   busy, done        state == LOAD, state == DONE
//   count             words written in the current session
//   err_illegal       sticky: undefined opcode consumed
//   err_overflow      sticky: memory filled before HLT
module instr_load_encoder #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              err_overflow
);

  localparam logic [ADDR_W-1:0] START_PTR = ADDR_W'(START_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              legal;
  logic              is_hlt;
  logic              last_addr;
  logic [31:0]       word;

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state == S_LOAD);
  assign done      = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign last_addr = (ptr == '1);

  // Field packing; fields a format does not use are forced to zero.
  always_comb begin
    word   = '0;
    legal  = 1'b1;
    is_hlt = 1'b0;
    case (in_opcode)
      6'b000000, 6'b000001, 6'b000010,
      6'b000011, 6'b000100, 6'b000101:
        word = {in_opcode, in_rs, in_rt, in_rd, 11'b0};
      6'b001000, 6'b001001, 6'b001010,
      6'b001011, 6'b001100:
        word = {in_opcode, in_rs, in_rt, in_imm};
      6'b001101, 6'b001110:
        word = {in_opcode, in_rs, 5'b0, in_imm};
      6'b001111:
        word = {in_opcode, 10'b0, in_imm};
      6'b111111: begin
        word   = {in_opcode, 26'b0};
        is_hlt = 1'b1;
      end
      default:
        legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE:
        if (start) state_next = S_LOAD;
      S_LOAD:
        if (accept && legal && (is_hlt || last_addr)) state_next = S_DONE;
      default:
        state_next = S_IDLE;
    endcase
  end

  // Write stage and session bookkeeping. The pointer saturates at the last
  // address rather than wrapping; the session ends there anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= START_PTR;
      count        <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= START_PTR;
      imem_wdata   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (state != S_LOAD && start) begin
        ptr          <= START_PTR;
        count        <= '0;
        err_illegal  <= 1'b0;
        err_overflow <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          imem_we    <= 1'b1;
          imem_addr  <= ptr;
          imem_wdata <= word;
          count      <= count + (ADDR_W+1)'(1);
          if (last_addr) begin
            if (!is_hlt) err_overflow <= 1'b1;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end else begin
          err_illegal <= 1'b1;
        end
      end
    end
  end

endmodule
